// File: rtl/spi_master_tx.sv
// ----------------------------------------------------------------------------
// spi_master_tx
//   SPI initiator, mode 0 (SCLK idles low), MSB first. One frame sends exactly
//   MSB clock pulses with CS low and simultaneously shifts MISO in; the
//   received word appears on rx_data together with the done pulse.
//
// Parameters
//   MSB     word width in bits (>= 2)
//   CLKDIV  clk cycles per SCLK half-period (>= 1); SCLK = clk / (2*CLKDIV)
//
// Ports
//   clk      in   system clock, all logic on posedge
//   rst      in   synchronous reset, active high
//   start    in   frame request, sampled only while busy = 0
//   data     in   word to send, captured when start is accepted
//   busy     out  frame in progress, including the CS-high gap
//   done     out  one-cycle pulse at frame completion
//   rx_data  out  word shifted in from miso, valid from done until next done
//   sclk     out  SPI clock
//   cs       out  chip select, active low
//   mosi     out  serial data out
//   miso     in   serial data in
//
// Frame timing: cs low (2*MSB+1)*CLKDIV cycles, busy high (2*MSB+2)*CLKDIV
// cycles, one IDLE cycle minimum between frames when start is held high.
// ----------------------------------------------------------------------------
module spi_master_tx #(
  parameter int unsigned MSB    = 8,
  parameter int unsigned CLKDIV = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [MSB-1:0] data,
  output logic           busy,
  output logic           done,
  output logic [MSB-1:0] rx_data,
  output logic           sclk,
  output logic           cs,
  output logic           mosi,
  input  logic           miso
);

  localparam int unsigned CW = $clog2(CLKDIV + 1);
  localparam int unsigned BW = $clog2(MSB);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOW  = 3'd1,
    S_HIGH = 3'd2,
    S_HOLD = 3'd3,
    S_GAP  = 3'd4
  } state_t;

  // Registered state
  state_t          r_state;
  logic [CW-1:0]   r_phase;
  logic [BW-1:0]   r_bitcnt;
  logic [MSB-1:0]  r_shift;
  logic [MSB-1:0]  r_rx_shift;
  logic [MSB-1:0]  r_rx_data;
  logic            r_sclk;
  logic            r_cs;
  logic            r_busy;
  logic            r_done;

  // Next-state values
  state_t          w_state_nxt;
  logic [CW-1:0]   w_phase_nxt;
  logic [BW-1:0]   w_bitcnt_nxt;
  logic [MSB-1:0]  w_shift_nxt;
  logic [MSB-1:0]  w_rx_shift_nxt;
  logic [MSB-1:0]  w_rx_data_nxt;
  logic            w_sclk_nxt;
  logic            w_cs_nxt;
  logic            w_busy_nxt;
  logic            w_done_nxt;
  logic            w_phase_end;

  // Last cycle of the current CLKDIV-long phase
  assign w_phase_end = (r_phase == CW'(CLKDIV - 1));

  // mosi is the top bit of the tx shift register; the register is cleared
  // when the frame leaves HOLD so mosi is 0 in GAP and IDLE.
  assign mosi    = r_shift[MSB-1];
  assign sclk    = r_sclk;
  assign cs      = r_cs;
  assign busy    = r_busy;
  assign done    = r_done;
  assign rx_data = r_rx_data;

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt    = r_state;
    w_phase_nxt    = r_phase;
    w_bitcnt_nxt   = r_bitcnt;
    w_shift_nxt    = r_shift;
    w_rx_shift_nxt = r_rx_shift;
    w_rx_data_nxt  = r_rx_data;
    w_sclk_nxt     = r_sclk;
    w_cs_nxt       = r_cs;
    w_busy_nxt     = r_busy;
    w_done_nxt     = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        w_sclk_nxt = 1'b0;
        w_cs_nxt   = 1'b1;
        if (start) begin
          w_state_nxt  = S_LOW;
          w_phase_nxt  = '0;
          w_bitcnt_nxt = BW'(MSB - 1);
          w_shift_nxt  = data;
          w_cs_nxt     = 1'b0;
          w_busy_nxt   = 1'b1;
        end
      end

      S_LOW: begin
        if (w_phase_end) begin
          // Rising sclk edge: miso is captured on the same clk edge
          w_state_nxt    = S_HIGH;
          w_phase_nxt    = '0;
          w_sclk_nxt     = 1'b1;
          w_rx_shift_nxt = {r_rx_shift[MSB-2:0], miso};
        end else begin
          w_phase_nxt = r_phase + CW'(1);
        end
      end

      S_HIGH: begin
        if (w_phase_end) begin
          // Falling sclk edge: the only point where mosi may advance
          w_phase_nxt = '0;
          w_sclk_nxt  = 1'b0;
          if (r_bitcnt != '0) begin
            w_state_nxt  = S_LOW;
            w_bitcnt_nxt = r_bitcnt - BW'(1);
            w_shift_nxt  = {r_shift[MSB-2:0], 1'b0};
          end else begin
            w_state_nxt = S_HOLD;
          end
        end else begin
          w_phase_nxt = r_phase + CW'(1);
        end
      end

      S_HOLD: begin
        if (w_phase_end) begin
          // End of CS hold: release cs, publish received word
          w_state_nxt   = S_GAP;
          w_phase_nxt   = '0;
          w_cs_nxt      = 1'b1;
          w_shift_nxt   = '0;
          w_rx_data_nxt = r_rx_shift;
          w_done_nxt    = 1'b1;
        end else begin
          w_phase_nxt = r_phase + CW'(1);
        end
      end

      S_GAP: begin
        if (w_phase_end) begin
          w_state_nxt = S_IDLE;
          w_phase_nxt = '0;
          w_busy_nxt  = 1'b0;
        end else begin
          w_phase_nxt = r_phase + CW'(1);
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_phase_nxt = '0;
        w_sclk_nxt  = 1'b0;
        w_cs_nxt    = 1'b1;
        w_shift_nxt = '0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_phase    <= '0;
      r_bitcnt   <= '0;
      r_shift    <= '0;
      r_rx_shift <= '0;
      r_rx_data  <= '0;
      r_sclk     <= 1'b0;
      r_cs       <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_phase    <= w_phase_nxt;
      r_bitcnt   <= w_bitcnt_nxt;
      r_shift    <= w_shift_nxt;
      r_rx_shift <= w_rx_shift_nxt;
      r_rx_data  <= w_rx_data_nxt;
      r_sclk     <= w_sclk_nxt;
      r_cs       <= w_cs_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
    end
  end

endmodule

// File: tb/tb_spi_master_tx.sv
// ----------------------------------------------------------------------------
// tb_spi_master_tx
//   Directed bench for spi_master_tx. u_dut0 (MSB=8, CLKDIV=2) runs with miso
//   looped back from mosi and feeds a clk-domain model of an SPI slave latch
//   that keeps a word only when a frame carried exactly 8 sclk rises.
//   u_dut1 (MSB=8, CLKDIV=1) receives a fixed miso pattern.
// ----------------------------------------------------------------------------
module tb_spi_master_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst    = 1'b1;
  logic       start0 = 1'b0;
  logic [7:0] data0  = 8'h00;
  logic       busy0, done0, sclk0, cs0, mosi0, miso0;
  logic [7:0] rx0;

  logic       start1 = 1'b0;
  logic [7:0] data1  = 8'h00;
  logic       busy1, done1, sclk1, cs1, mosi1;
  logic       miso1  = 1'b0;
  logic [7:0] rx1;

  assign miso0 = mosi0;

  spi_master_tx #(.MSB(8), .CLKDIV(2)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .data(data0), .busy(busy0),
    .done(done0), .rx_data(rx0), .sclk(sclk0), .cs(cs0), .mosi(mosi0),
    .miso(miso0)
  );

  spi_master_tx #(.MSB(8), .CLKDIV(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .data(data1), .busy(busy1),
    .done(done1), .rx_data(rx1), .sclk(sclk1), .cs(cs1), .mosi(mosi1),
    .miso(miso1)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Slave latch model: shift mosi on sclk rise while cs low, keep word on cs
  // rise only if exactly 8 bits were clocked.
  logic       sl_sclk_q = 1'b0;
  logic       sl_cs_q   = 1'b1;
  logic [3:0] sl_cnt    = 4'd0;
  logic [7:0] sl_shift  = 8'h00;
  logic [7:0] sl_out    = 8'h00;

  always @(posedge clk) begin
    sl_sclk_q <= sclk0;
    sl_cs_q   <= cs0;
    if (cs0 && !sl_cs_q) begin
      if (sl_cnt == 4'd8) sl_out <= sl_shift;
      sl_cnt <= 4'd0;
    end else if (!cs0 && sclk0 && !sl_sclk_q) begin
      sl_shift <= {sl_shift[6:0], mosi0};
      sl_cnt   <= sl_cnt + 4'd1;
    end
  end

  // Per-frame statistics gathered by send0
  int         st_rise, st_cslo, st_busy, st_done, st_glitch;
  logic [7:0] st_bits;
  logic       st_first_busy, st_first_cs, st_first_mosi;

  // Issue one start on dut0 and observe ncyc cycles; optionally re-pulse
  // start with inj_d at observed cycle inj_at.
  task automatic send0(input logic [7:0] d, input int ncyc,
                       input int inj_at, input logic [7:0] inj_d);
    logic prev_sclk, prev_mosi;
    @(negedge clk);
    start0 = 1'b1;
    data0  = d;
    @(negedge clk);
    start0 = 1'b0;
    data0  = ~d;
    st_first_busy = busy0;
    st_first_cs   = cs0;
    st_first_mosi = mosi0;
    st_rise = 0; st_cslo = 0; st_busy = 0; st_done = 0; st_glitch = 0;
    st_bits = 8'h00;
    prev_sclk = 1'b0;
    prev_mosi = mosi0;
    for (int i = 0; i < ncyc; i++) begin
      if (i > 0) @(negedge clk);
      if (i == inj_at) begin
        start0 = 1'b1;
        data0  = inj_d;
      end else if (i == inj_at + 1) begin
        start0 = 1'b0;
      end
      if (!cs0)  st_cslo++;
      if (busy0) st_busy++;
      if (done0) st_done++;
      if (sclk0 && !prev_sclk) begin
        st_rise++;
        st_bits = {st_bits[6:0], mosi0};
      end
      if (sclk0 && prev_sclk && (mosi0 !== prev_mosi)) st_glitch++;
      prev_sclk = sclk0;
      prev_mosi = mosi0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (busy0 !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy0); end
    n_cmp++; if (done0 !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", done0); end
    n_cmp++; if (rx0 !== 8'h00) begin n_err++; $display("FAIL reset_rx: got %h expected 00", rx0); end
    n_cmp++; if (sclk0 !== 1'b0) begin n_err++; $display("FAIL reset_sclk: got %b expected 0", sclk0); end
    n_cmp++; if (cs0 !== 1'b1) begin n_err++; $display("FAIL reset_cs: got %b expected 1", cs0); end
    n_cmp++; if (mosi0 !== 1'b0) begin n_err++; $display("FAIL reset_mosi: got %b expected 0", mosi0); end
    n_cmp++; if (cs1 !== 1'b1) begin n_err++; $display("FAIL reset_cs1: got %b expected 1", cs1); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_frame();
    send0(8'hA5, 50, -1, 8'h00);
    n_cmp++; if (st_first_busy !== 1'b1) begin n_err++; $display("FAIL t1_first_busy: got %b expected 1", st_first_busy); end
    n_cmp++; if (st_first_cs !== 1'b0) begin n_err++; $display("FAIL t1_first_cs: got %b expected 0", st_first_cs); end
    n_cmp++; if (st_first_mosi !== 1'b1) begin n_err++; $display("FAIL t1_first_mosi: got %b expected 1", st_first_mosi); end
    n_cmp++; if (st_cslo != 34) begin n_err++; $display("FAIL t1_cs_low: got %0d expected 34", st_cslo); end
    n_cmp++; if (st_busy != 36) begin n_err++; $display("FAIL t1_busy: got %0d expected 36", st_busy); end
    n_cmp++; if (st_done != 1) begin n_err++; $display("FAIL t1_done: got %0d expected 1", st_done); end
    n_cmp++; if (st_rise != 8) begin n_err++; $display("FAIL t1_sclk: got %0d expected 8", st_rise); end
    n_cmp++; if (st_bits !== 8'hA5) begin n_err++; $display("FAIL t1_mosi_bits: got %h expected a5", st_bits); end
    n_cmp++; if (st_glitch != 0) begin n_err++; $display("FAIL t1_mosi_stable: got %0d expected 0", st_glitch); end
    n_cmp++; if (rx0 !== 8'hA5) begin n_err++; $display("FAIL t1_rx: got %h expected a5", rx0); end
  endtask

  task automatic test_back_to_back();
    logic       prev_cs, prev_sclk;
    int         frames, rises, hi_run;
    logic [7:0] bits;
    frames = 0; rises = 0; hi_run = 0; bits = 8'h00;
    prev_cs = 1'b1; prev_sclk = 1'b0;
    @(negedge clk);
    start0 = 1'b1;
    data0  = 8'h3C;
    for (int i = 0; i < 130; i++) begin
      @(negedge clk);
      if (sclk0 && !prev_sclk) begin
        rises++;
        bits = {bits[6:0], mosi0};
      end
      if (!cs0 && prev_cs) begin
        if (frames > 0) begin
          n_cmp++; if (hi_run != 3) begin n_err++; $display("FAIL t2_cs_gap: got %0d expected 3", hi_run); end
        end
        rises = 0;
      end
      if (cs0 && !prev_cs) begin
        frames++;
        n_cmp++; if (rises != 8) begin n_err++; $display("FAIL t2_sclk: got %0d expected 8", rises); end
        n_cmp++; if (bits !== 8'h3C) begin n_err++; $display("FAIL t2_bits: got %h expected 3c", bits); end
        hi_run = 0;
      end
      if (cs0) hi_run++;
      prev_cs   = cs0;
      prev_sclk = sclk0;
    end
    start0 = 1'b0;
    for (int i = 0; i < 80 && busy0; i++) @(negedge clk);
    n_cmp++; if (busy0 !== 1'b0) begin n_err++; $display("FAIL t2_drain: busy got %b expected 0", busy0); end
    n_cmp++; if (frames < 3) begin n_err++; $display("FAIL t2_frames: got %0d expected >=3", frames); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_start_ignored();
    send0(8'hFF, 50, 9, 8'h00);
    n_cmp++; if (st_rise != 8) begin n_err++; $display("FAIL t3_sclk: got %0d expected 8", st_rise); end
    n_cmp++; if (st_bits !== 8'hFF) begin n_err++; $display("FAIL t3_bits: got %h expected ff", st_bits); end
    n_cmp++; if (st_cslo != 34) begin n_err++; $display("FAIL t3_cs_low: got %0d expected 34", st_cslo); end
    n_cmp++; if (st_done != 1) begin n_err++; $display("FAIL t3_done: got %0d expected 1", st_done); end
    repeat (5) @(negedge clk);
    n_cmp++; if (rx0 !== 8'hFF) begin n_err++; $display("FAIL t3_rx_held: got %h expected ff", rx0); end
  endtask

  task automatic test_latch_send();
    send0(8'h02, 45, -1, 8'h00);
    n_cmp++; if (sl_out !== 8'h02) begin n_err++; $display("FAIL t5_latch: got %h expected 02", sl_out); end
  endtask

  task automatic test_mid_reset();
    logic prev_sclk;
    int   rises, dones, cslo;
    rises = 0; dones = 0; cslo = 0; prev_sclk = 1'b0;
    @(negedge clk);
    start0 = 1'b1;
    data0  = 8'hA5;
    for (int i = 0; i < 40 && rises < 3; i++) begin
      @(negedge clk);
      start0 = 1'b0;
      if (sclk0 && !prev_sclk) rises++;
      prev_sclk = sclk0;
    end
    n_cmp++; if (rises != 3) begin n_err++; $display("FAIL t4_reach_rise3: got %0d expected 3", rises); end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (cs0 !== 1'b1) begin n_err++; $display("FAIL t4_cs: got %b expected 1", cs0); end
    n_cmp++; if (sclk0 !== 1'b0) begin n_err++; $display("FAIL t4_sclk: got %b expected 0", sclk0); end
    n_cmp++; if (busy0 !== 1'b0) begin n_err++; $display("FAIL t4_busy: got %b expected 0", busy0); end
    n_cmp++; if (mosi0 !== 1'b0) begin n_err++; $display("FAIL t4_mosi: got %b expected 0", mosi0); end
    n_cmp++; if (rx0 !== 8'h00) begin n_err++; $display("FAIL t4_rx: got %h expected 00", rx0); end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done0) dones++;
      if (!cs0)  cslo++;
    end
    n_cmp++; if (dones != 0) begin n_err++; $display("FAIL t4_no_done: got %0d expected 0", dones); end
    n_cmp++; if (cslo != 0) begin n_err++; $display("FAIL t4_cs_idle: got %0d expected 0", cslo); end
    n_cmp++; if (sl_out !== 8'h02) begin n_err++; $display("FAIL t5_latch_kept: got %h expected 02", sl_out); end
    send0(8'h81, 45, -1, 8'h00);
    n_cmp++; if (st_rise != 8) begin n_err++; $display("FAIL t4_sclk_after: got %0d expected 8", st_rise); end
    n_cmp++; if (st_bits !== 8'h81) begin n_err++; $display("FAIL t4_bits_after: got %h expected 81", st_bits); end
    n_cmp++; if (rx0 !== 8'h81) begin n_err++; $display("FAIL t4_rx_after: got %h expected 81", rx0); end
    n_cmp++; if (sl_out !== 8'h81) begin n_err++; $display("FAIL t5_latch_after: got %h expected 81", sl_out); end
  endtask

  task automatic test_clkdiv1_rx();
    logic [7:0] pat;
    logic [7:0] bits;
    logic       prev_sclk;
    int         idx, rises, bz, cslo, dones;
    pat = 8'hC3; bits = 8'h00; prev_sclk = 1'b0;
    idx = 0; rises = 0; bz = 0; cslo = 0; dones = 0;
    miso1 = pat[7];
    @(negedge clk);
    start1 = 1'b1;
    data1  = 8'h5A;
    @(negedge clk);
    start1 = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (i > 0) @(negedge clk);
      if (busy1) bz++;
      if (!cs1)  cslo++;
      if (done1) dones++;
      if (sclk1 && !prev_sclk) begin
        rises++;
        bits = {bits[6:0], mosi1};
      end
      if (!sclk1 && prev_sclk) begin
        idx++;
        if (idx < 8) miso1 = pat[3'(7 - idx)];
      end
      prev_sclk = sclk1;
    end
    n_cmp++; if (bz != 18) begin n_err++; $display("FAIL t6_busy: got %0d expected 18", bz); end
    n_cmp++; if (cslo != 17) begin n_err++; $display("FAIL t6_cs_low: got %0d expected 17", cslo); end
    n_cmp++; if (rises != 8) begin n_err++; $display("FAIL t6_sclk: got %0d expected 8", rises); end
    n_cmp++; if (bits !== 8'h5A) begin n_err++; $display("FAIL t6_bits: got %h expected 5a", bits); end
    n_cmp++; if (dones != 1) begin n_err++; $display("FAIL t6_done: got %0d expected 1", dones); end
    n_cmp++; if (rx1 !== 8'hC3) begin n_err++; $display("FAIL t6_rx: got %h expected c3", rx1); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_start_ignored();
    test_latch_send();
    test_mid_reset();
    test_clkdiv1_rx();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
